// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes,
// opcode/funct constants and the datapath select values.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BR       = 4'd9,
    S_JMP      = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ALU_LO = 6'h20;
  localparam logic [5:0] FN_ALU_HI = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC  = 2'd2;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_DECODE = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  function automatic logic is_rtype_alu(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA) ||
           ((funct >= FN_ALU_LO) && (funct <= FN_ALU_HI)) ||
           (funct == FN_SLT) || (funct == FN_SLTU);
  endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational next-state and control-signal decode for the multicycle
// control unit; enables are forced low while reset is asserted.
module multicycle_decode
  import multicycle_pkg::*;
(
  input  logic       reset,
  input  state_t     state,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output state_t     next_state,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       IllegalOp
);

  logic pc_write_s;
  logic pc_write_cond_s;
  logic mem_read_s;
  logic mem_write_s;
  logic ir_write_s;
  logic reg_write_s;
  logic instr_done_s;
  logic illegal_op_s;

  // State transition and per-state control decode
  always_comb begin
    next_state      = S_IF;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    instr_done_s    = 1'b0;
    illegal_op_s    = 1'b0;
    IorD            = 1'b0;
    ExtOp           = 1'b0;
    LuOp            = 1'b0;
    MemtoReg        = MTR_ALU;
    RegDst          = DST_RD;
    ALUSrcA         = SRCA_PC;
    ALUSrcB         = SRCB_RT;
    ALUOp           = ALUOP_ADD;
    PCSource        = PCSRC_ALU;
    case (state)
      S_IF: begin
        mem_read_s = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        next_state = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB = SRCB_IMM_SL2;
        ExtOp   = 1'b1;
        case (OpCode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BR;
          OP_J, OP_JAL: next_state = S_JMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
            next_state = S_EX_I;
          OP_RTYPE: begin
            if ((Funct == FN_JR) || (Funct == FN_JALR)) begin
              next_state = S_JMP;
            end else if (is_rtype_alu(Funct)) begin
              next_state = S_EX_R;
            end else begin
              illegal_op_s = 1'b1;
              next_state   = S_IF;
            end
          end
          default: begin
            illegal_op_s = 1'b1;
            next_state   = S_IF;
          end
        endcase
      end
      S_EX_R: begin
        // Shifts take their A operand from the shamt field
        ALUSrcA    = ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA))
                     ? SRCA_SHAMT : SRCA_RS;
        ALUSrcB    = SRCB_RT;
        ALUOp      = ALUOP_DECODE;
        next_state = S_WB_ALU;
      end
      S_EX_I: begin
        ALUSrcA    = SRCA_RS;
        ALUSrcB    = SRCB_IMM;
        ALUOp      = ALUOP_DECODE;
        ExtOp      = (OpCode != OP_ANDI);
        LuOp       = (OpCode == OP_LUI);
        next_state = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write_s  = 1'b1;
        MemtoReg     = MTR_ALU;
        RegDst       = (OpCode == OP_RTYPE) ? DST_RD : DST_RT;
        instr_done_s = 1'b1;
        next_state   = S_IF;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = SRCA_RS;
        ALUSrcB    = SRCB_IMM;
        ExtOp      = 1'b1;
        ALUOp      = ALUOP_ADD;
        next_state = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        IorD       = 1'b1;
        next_state = mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_write_s  = 1'b1;
        IorD         = 1'b1;
        instr_done_s = mem_ready;
        next_state   = mem_ready ? S_IF : S_MEM_WR;
      end
      S_WB_MEM: begin
        reg_write_s  = 1'b1;
        MemtoReg     = MTR_MEM;
        RegDst       = DST_RT;
        instr_done_s = 1'b1;
        next_state   = S_IF;
      end
      S_BR: begin
        ALUSrcA         = SRCA_RS;
        ALUSrcB         = SRCB_RT;
        ALUOp           = ALUOP_SUB;
        pc_write_cond_s = 1'b1;
        PCSource        = PCSRC_ALUOUT;
        instr_done_s    = 1'b1;
        next_state      = S_IF;
      end
      S_JMP: begin
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
        PCSource     = (OpCode == OP_RTYPE) ? PCSRC_RS : PCSRC_JUMP;
        if (OpCode == OP_JAL) begin
          reg_write_s = 1'b1;
          RegDst      = DST_RA;
          MemtoReg    = MTR_PC;
        end else if ((OpCode == OP_RTYPE) && (Funct == FN_JALR)) begin
          reg_write_s = 1'b1;
          RegDst      = DST_RD;
          MemtoReg    = MTR_PC;
        end else begin
          reg_write_s = 1'b0;
        end
        next_state = S_IF;
      end
      default: next_state = S_IF;
    endcase
  end

  assign PCWrite     = pc_write_s & reset;
  assign PCWriteCond = pc_write_cond_s & reset;
  assign MemRead     = mem_read_s & reset;
  assign MemWrite    = mem_write_s & reset;
  assign IRWrite     = ir_write_s & reset;
  assign RegWrite    = reg_write_s & reset;
  assign InstrDone   = instr_done_s & reset;
  assign IllegalOp   = illegal_op_s & reset;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit top: holds the state register and the
// retired-instruction counter; all decode lives in multicycle_decode.
module multicycle_control
  import multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ExtOp,
  output logic        LuOp,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  RegDst,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic        InstrDone,
  output logic        IllegalOp,
  output logic [31:0] InstrCount
);

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] count_r;

  multicycle_decode u_decode (
    .reset       (reset),
    .state       (state_r),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .mem_ready   (mem_ready),
    .next_state  (next_state_s),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .ExtOp       (ExtOp),
    .LuOp        (LuOp),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .InstrDone   (InstrDone),
    .IllegalOp   (IllegalOp)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 32'd0;
    end else if (InstrDone) begin
      count_r <= count_r + 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign State      = state_r;
  assign InstrCount = count_r;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have OpCode, input, 6, Instruction[31:26] from the instruction register.
REQ-004 SHALL have Funct, input, 6, Instruction[5:0] from the instruction register.
REQ-005 SHALL have mem_ready, input, 1, memory handshake; access completes in a cycle where it is 1.
REQ-006 SHALL have 1-bit enable outputs: PCWrite, PCWriteCond, IorD (0 PC, 1 ALUOut), MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuOp.
REQ-007 SHALL have 2-bit select outputs:
- MemtoReg: 0 ALU, 1 mem, 2 PC.
- RegDst: 0 rd, 1 rt, 2 $31.
- ALUSrcA: 0 PC, 1 rs, 2 shamt.
- ALUSrcB: 0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2.
- ALUOp: 0 add, 1 sub, 2 decode.
- PCSource: 0 ALU, 1 ALUOut, 2 jump target, 3 rs.
REQ-008 SHALL have State, output, 4, current state code.
REQ-009 SHALL have InstrDone, output, 1, high in the last cycle of each legal instruction.
REQ-010 SHALL have IllegalOp, output, 1, high in the ID cycle of an undecoded opcode or funct.
REQ-011 SHALL have InstrCount, output, 32, count of retired instructions.

Function
REQ-012 States SHALL be IF=0, ID=1, EX_R=2, EX_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_MEM=7, WB_ALU=8, BR=9, JMP=10; codes 11-15 SHALL go to IF next cycle with all enables low.
REQ-013 Any output not listed for a state SHALL be 0.
REQ-014 IF SHALL drive MemRead=1, ALUSrcB=1, ALUOp=0, PCSource=0.
- IRWrite and PCWrite SHALL equal mem_ready.
- SHALL stay in IF while mem_ready=0, else go to ID.
REQ-015 ID SHALL drive ALUSrcB=3, ExtOp=1, ALUOp=0.
- Next state: lw(0x23)/sw(0x2B) go to MEM_ADDR; beq(0x04) to BR; j(0x02), jal(0x03), R-type jr(0x08)/jalr(0x09) to JMP.
- Other R-type funct in {00,02,03,20-27,2A,2B} goes to EX_R; addi/addiu/slti/sltiu/andi/lui (08,09,0A,0B,0C,0F) go to EX_I.
- Anything else goes to IF with IllegalOp=1.
REQ-016 EX_R SHALL drive ALUSrcB=0 and ALUOp=2, with ALUSrcA=2 for funct 00/02/03 and 1 otherwise; next state WB_ALU.
REQ-017 EX_I SHALL drive ALUSrcA=1, ALUSrcB=2, ALUOp=2, ExtOp=(OpCode!=0x0C), LuOp=(OpCode==0x0F); next state WB_ALU.
REQ-018 WB_ALU SHALL drive RegWrite=1, MemtoReg=0, RegDst=(OpCode==0?0:1), InstrDone=1; next state IF.
REQ-019 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp=0; next state MEM_RD for lw, MEM_WR for sw.
REQ-020 MEM_RD SHALL drive MemRead=1, IorD=1 and hold until mem_ready=1, then go to WB_MEM.
REQ-021 MEM_WR SHALL drive MemWrite=1, IorD=1 and hold until mem_ready=1; in that cycle InstrDone=1 and next state is IF.
REQ-022 WB_MEM SHALL drive RegWrite=1, MemtoReg=1, RegDst=1, InstrDone=1; next state IF.
REQ-023 BR SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, InstrDone=1; next state IF.
REQ-024 JMP SHALL drive PCWrite=1 and InstrDone=1, then go to IF.
- PCSource=2 for j/jal, 3 for jr/jalr.
- jal: RegWrite=1, RegDst=2, MemtoReg=2.
- jalr: RegWrite=1, RegDst=0, MemtoReg=2.
REQ-025 InstrCount SHALL increment by 1 on each rising edge where InstrDone=1, wrapping from 0xFFFFFFFF to 0.
REQ-026 All outputs SHALL be combinational from State, OpCode, Funct and mem_ready; only State and InstrCount are registered.

Reset
REQ-027 While reset=0, State SHALL be IF and InstrCount 0 immediately (asynchronous), with all enables forced 0.
- Forced-low enables: PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, InstrDone, IllegalOp.
REQ-028 Reset asserted mid-instruction SHALL abandon that instruction; after release, execution SHALL start at IF on the next edge.

Structure
REQ-029 A shared package multicycle_pkg SHALL hold state codes, opcode/funct constants, and all select encodings from REQ-007.
REQ-030 Output decode SHALL be one combinational sub-module multicycle_decode; the top module SHALL hold only the state and count registers.

Verification
REQ-031 add 0x00221820, mem_ready=1 -> State 0,1,2,8; cycle 4: RegWrite=1, RegDst=0, InstrDone=1; InstrCount=1.
REQ-032 lw 0x8C220004, mem_ready=0 for 2 cycles in MEM_RD -> MemRead=1 held 3 cycles, then WB_MEM with RegDst=1, MemtoReg=1; 7 cycles total.
REQ-033 beq 0x10220003 -> BR cycle: PCWriteCond=1, PCSource=1, ALUOp=1, PCWrite=0; 3 cycles.
REQ-034 jal 0x0C000010 -> JMP: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2.
REQ-035 reset=0 during MEM_WR with mem_ready=0 -> same cycle MemWrite=0, State=0, InstrCount=0.
REQ-036 OpCode 0x3F -> ID cycle IllegalOp=1, next State=0, InstrCount unchanged.
